// File: rtl/noc_cfg_scheduler_if.sv
// Request/mesh-side bundle for noc_cfg_scheduler: requester handshake, mesh
// completion/inhibit inputs, per-processor configure buses and done reporting.
interface noc_cfg_scheduler_if #(
    parameter int NUM_PROC = 4,
    parameter int CFG_W    = 11
);
    localparam int GW = $clog2(NUM_PROC);

    logic [NUM_PROC-1:0]       req_valid;
    logic [NUM_PROC*CFG_W-1:0] req_cfg;
    logic [NUM_PROC-1:0]       req_ready;
    logic                      block_all_paths;
    logic [NUM_PROC-1:0]       processor_ready_signals;
    logic [NUM_PROC*CFG_W-1:0] p_configure;
    logic                      busy;
    logic                      done;
    logic [GW-1:0]             done_id;
    logic [1:0]                done_status;

    modport master (
        output req_valid, req_cfg, block_all_paths, processor_ready_signals,
        input  req_ready, p_configure, busy, done, done_id, done_status
    );

    modport slave (
        input  req_valid, req_cfg, block_all_paths, processor_ready_signals,
        output req_ready, p_configure, busy, done, done_id, done_status
    );
endinterface

// File: rtl/noc_cfg_scheduler.sv
// Round-robin serialiser of path-configuration words onto the mesh configure buses.
// Optional DRIVE timeout abort built only when NOC_CFG_SCHED_TIMEOUT_EN is defined.
module noc_cfg_scheduler #(
    parameter int NUM_PROC = 4,
    parameter int CFG_W    = 11,
    parameter int TIMEOUT  = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    noc_cfg_scheduler_if.slave   bus
);
    localparam int GW = $clog2(NUM_PROC);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRIVE   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BLOCKED = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [GW-1:0]             last_q, last_d;
    logic [NUM_PROC*CFG_W-1:0] pcfg_q, pcfg_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [GW-1:0]             done_id_q, done_id_d;
    logic [1:0]                status_q, status_d;

    logic [GW-1:0]             win, idx;
    logic                      found;
    logic                      accept;
    logic                      tmo_hit;

    if (TIMEOUT < 2) begin : g_timeout_too_small
    end

    // Scan upward from last_grant+1; power-of-two NUM_PROC makes the wrap free.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PROC; k++) begin
            idx = last_q + GW'(k + 1);
            if (!found && bus.req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE && !bus.block_all_paths && found)
                         ? (NUM_PROC'(1) << win) : '0;
    assign accept = |(bus.req_valid & bus.req_ready);

`ifdef NOC_CFG_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] cnt_q;

    assign tmo_hit = (cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                   cnt_q <= '0;
        else if (accept)             cnt_q <= '0;
        else if (state_q == S_DRIVE) cnt_q <= cnt_q + TW'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        pcfg_d    = pcfg_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        status_d  = status_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DRIVE;
                    grant_d = win;
                    pcfg_d  = '0;
                    pcfg_d[int'(win)*CFG_W +: CFG_W] = bus.req_cfg[int'(win)*CFG_W +: CFG_W];
                end
            end
            S_DRIVE: begin
                // Block outranks ready, ready outranks timeout.
                if (bus.block_all_paths || bus.processor_ready_signals[grant_q] || tmo_hit) begin
                    state_d   = S_RELEASE;
                    pcfg_d    = '0;
                    done_d    = 1'b1;
                    done_id_d = grant_q;
                    last_d    = grant_q;
                    if (bus.block_all_paths)                       status_d = ST_BLOCKED;
                    else if (bus.processor_ready_signals[grant_q]) status_d = ST_OK;
                    else                                           status_d = ST_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_PROC - 1);
            pcfg_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            status_q  <= ST_OK;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            pcfg_q    <= pcfg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            status_q  <= status_d;
        end
    end

    assign bus.p_configure = pcfg_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.done_id     = done_id_q;
    assign bus.done_status = status_q;
endmodule

// File: doc/noc_cfg_scheduler.md
# noc_cfg_scheduler

Serialises path-configuration requests from the mesh's processors onto the per-processor `pN_configure` inputs of the 2x2 mesh. Only one configuration is in flight at a time. Requesters are served round-robin. Each word is held on the winner's configure bus until the mesh raises that processor's ready signal, or until the word is aborted by `block_all_paths` or by a timeout. It sits between the processor-side request logic and the mesh top.

## Interface
- `NUM_PROC`, 4: number of requesters; power of two, ≥2; `GW = log2(NUM_PROC)`.
- `CFG_W`, 11: configuration word width (opaque to this block).
- `TIMEOUT`, 64: maximum DRIVE cycles before abort; ≥2; used only with `NOC_CFG_SCHED_TIMEOUT_EN`.

Ports:
- `clock`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `req_valid`  in  NUM_PROC  — per-processor request pending.
- `req_cfg`  in  NUM_PROC*CFG_W  — request words; slice i = `[i*CFG_W +: CFG_W]`.
- `req_ready`  out  NUM_PROC  — one-hot accept; the transfer happens when `req_valid[i] & req_ready[i]`.
- `block_all_paths`  in  1  — global inhibit from the mesh.
- `processor_ready_signals`  in  NUM_PROC  — per-processor completion from the mesh.
- `p_configure`  out  NUM_PROC*CFG_W  — per-processor configure buses to the mesh.
- `busy`  out  1  — high in DRIVE or RELEASE.
- `done`  out  1  — one-cycle completion pulse.
- `done_id`  out  GW  — processor index for `done`.
- `done_status`  out  2  — 0 = ok, 1 = blocked, 2 = timeout; 3 is never driven.

## Operation
- FSM states: IDLE, DRIVE, RELEASE. Reset state is IDLE.
- On reset, every output is 0 and `last_grant = NUM_PROC-1`, so processor 0 has first priority. The timeout counter is 0.
- **IDLE**
  - If `!block_all_paths` and any `req_valid` is set, the winner is the first set bit scanning upward from `last_grant+1`, wrapping modulo NUM_PROC.
  - `req_ready` is combinational: the one-hot of the winner, asserted only in IDLE.
  - On the accepting edge: capture `req_cfg[winner]` into the winner's `p_configure` slice, record `grant = winner`, go to DRIVE.
  - If `block_all_paths` is high, `req_ready = 0` and the FSM stays in IDLE.
- **DRIVE**
  - The granted `p_configure` slice holds the word; all other slices are 0.
  - Exit conditions are evaluated each edge in priority order:
    1. `block_all_paths`: status 1.
    2. `processor_ready_signals[grant]`: status 0.
    3. Timeout expiry: status 2.
  - On exit: clear all of `p_configure`, set `done = 1`, `done_id = grant`, `done_status`, `last_grant = grant`, go to RELEASE.
- **RELEASE**
  - Exactly one cycle. `done` is high in this cycle only; `p_configure` is all 0.
  - Always returns to IDLE. Requests are ignored during this cycle.
- Ready bits of non-granted processors are ignored.
- A requester that drops `req_valid` before acceptance is simply skipped.
- Arbitration state (`last_grant`) updates only on completion, never on acceptance.

## Timing
- Acceptance latency: `req_ready` can rise in the same cycle `req_valid` rises, if the FSM is in IDLE and unblocked.
- The word appears on `p_configure` in the first cycle after the accepting edge.
- A ready signal already high at DRIVE entry completes after 1 DRIVE cycle.
- Minimum transaction is 3 cycles (IDLE accept, DRIVE, RELEASE), so maximum throughput is one configuration per 3 cycles.
- Timeout: the counter clears on DRIVE entry and increments each DRIVE cycle without an exit. It expires when `count == TIMEOUT-1`, so a timed-out DRIVE lasts exactly TIMEOUT cycles.
- Asynchronous reset in any state forces the reset values immediately. No `done` pulse is issued for an interrupted transaction.
- `busy`, `done`, `done_id` and `done_status` are registered. `req_ready` is the only combinational output.

## Configuration
- `NOC_CFG_SCHED_TIMEOUT_EN` defined: the timeout counter and `done_status = 2` path are present.
- `NOC_CFG_SCHED_TIMEOUT_EN` undefined: no counter is built. DRIVE exits only on block or ready, and `done_status` is never 2.

## Test plan
- **Reset:** assert `reset` mid-DRIVE, holding word `11'b00001000011` on slice 0. Required: all `p_configure` slices read 0 immediately, `busy = 0`, `done = 0`. The next request from any processor wins priority starting at processor 0.
- **Single request:** `req_valid[0]` with `11'h043` in IDLE. Required: `req_ready = 4'b0001` in the same cycle, and slice 0 = `11'h043` the next cycle. Raise `processor_ready_signals[0]` 5 cycles later. Required: `done = 1` with `done_id = 0`, status 0, slice 0 cleared, and `busy` falls one cycle after `done`.
- **Round-robin:** all four `req_valid` held with ready returned promptly. Required: grant order 0, 1, 2, 3, 0. Each grant is separated by at least 3 cycles.
- **Block:** hold `block_all_paths` high in IDLE with `req_valid = 4'b0100`. Required: `req_ready = 0`. Release it: processor 2 is granted. Assert `block_all_paths` during DRIVE. Required: `done_status = 1` and slice 2 cleared.
- **Timeout (`TIMEOUT = 8`, macro defined):** ready is never raised. Required: exactly 8 DRIVE cycles, then `done_status = 2`. With the macro undefined, the FSM stays in DRIVE for at least 100 cycles.
- **Ready precedence:** ready and `block_all_paths` asserted in the same cycle. Required: `done_status = 1`. A ready from a non-granted processor has no effect.
